rvc_asap_dmem_arb: RTL and testbench

Arbiter and sequencer for the core's single-port data memory (8 KB, byte addresses 0x0000–0x1FFF). It shares that memory between two requesters:
- the core load/store path (port Core);
- an external loader/debug port (port Ext).

It performs range and alignment checks, drives the synchronous SRAM, and routes the one-cycle-latency read response back to the winning requester. It sits between the core memory stage and the data memory instance.

---
 rtl/rvc_asap_dmem_arb_if.sv | 56 +++++
 rtl/rvc_asap_dmem_arb.sv | 116 +++++++++++
 tb/tb_rvc_asap_dmem_arb.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/rvc_asap_dmem_arb_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the SRAM.
// Port summary: core_* / ext_* request fields in, grant and response out;
//               mem_* drive the single-port SRAM, mem_rd_dat returns read data.
// The slave modport is the arbiter's view; master is the requester/SRAM view.
interface rvc_asap_dmem_arb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MEM_AW = 13
);
  // Core load/store path
  logic              core_req;
  logic              core_wr;
  logic [31:0]       core_addr;
  logic [DATA_W-1:0] core_wr_dat;
  logic [3:0]        core_byte_en;
  logic              core_gnt;
  logic              core_rd_vld;
  logic [DATA_W-1:0] core_rd_dat;
  logic              core_err;

  // External loader/debug path
  logic              ext_req;
  logic              ext_wr;
  logic [31:0]       ext_addr;
  logic [DATA_W-1:0] ext_wr_dat;
  logic [3:0]        ext_byte_en;
  logic              ext_gnt;
  logic              ext_rd_vld;
  logic [DATA_W-1:0] ext_rd_dat;
  logic              ext_err;

  // Synchronous SRAM
  logic              mem_en;
  logic              mem_wr;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_dat;
  logic [3:0]        mem_byte_en;
  logic [DATA_W-1:0] mem_rd_dat;

  modport slave (
    input  core_req, core_wr, core_addr, core_wr_dat, core_byte_en,
    output core_gnt, core_rd_vld, core_rd_dat, core_err,
    input  ext_req, ext_wr, ext_addr, ext_wr_dat, ext_byte_en,
    output ext_gnt, ext_rd_vld, ext_rd_dat, ext_err,
    output mem_en, mem_wr, mem_addr, mem_wr_dat, mem_byte_en,
    input  mem_rd_dat
  );

  modport master (
    output core_req, core_wr, core_addr, core_wr_dat, core_byte_en,
    input  core_gnt, core_rd_vld, core_rd_dat, core_err,
    output ext_req, ext_wr, ext_addr, ext_wr_dat, ext_byte_en,
    input  ext_gnt, ext_rd_vld, ext_rd_dat, ext_err,
    input  mem_en, mem_wr, mem_addr, mem_wr_dat, mem_byte_en,
    output mem_rd_dat
  );
endinterface

// File: rtl/rvc_asap_dmem_arb.sv
// Data-memory arbiter: shares one synchronous SRAM between core and ext requesters,
// with range/alignment checking and a one-stage response pipeline.
// Ports: clk, rst_n (synchronous, active-low), bus (slave modport: requests,
//        grants, responses, SRAM drive). Latency: grant same cycle, response +1 cycle.
// Backpressure: loser of a contested cycle sees gnt=0 and must hold its request.
module rvc_asap_dmem_arb #(
  parameter int unsigned DATA_W     = 32,
  parameter logic [31:0] MEM_MSB    = 32'h0000_1FFF,
  parameter int unsigned MEM_AW     = 13,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rvc_asap_dmem_arb_if.slave    bus
);

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_EXT  = 1'b1
  } owner_e;

  logic [2:0] starve_q, starve_d;
  logic       rsp_vld_q, rsp_vld_d;
  owner_e     rsp_owner_q, rsp_owner_d;
  logic       rsp_err_q, rsp_err_d;
  logic       rsp_is_rd_q, rsp_is_rd_d;

  logic              both_req;
  logic              ext_forced;
  logic              core_gnt;
  logic              ext_gnt;
  logic              any_gnt;
  logic              sel_wr;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wr_dat;
  logic [3:0]        sel_byte_en;
  logic              legal;
  logic              access;
  logic              rsp_live;
  logic [DATA_W-1:0] rsp_dat;

  // Arbitration, access checking and SRAM drive.
  always_comb begin
    both_req   = bus.core_req && bus.ext_req;
    // Ext only beats the core once it has lost MAX_STARVE contested cycles.
    ext_forced = both_req && (starve_q == 3'(MAX_STARVE));
    // Grants are suppressed while in reset so nothing is accepted then.
    core_gnt   = rst_n && bus.core_req && !ext_forced;
    ext_gnt    = rst_n && bus.ext_req && (!bus.core_req || ext_forced);
    any_gnt    = core_gnt || ext_gnt;

    sel_wr      = ext_gnt ? bus.ext_wr       : bus.core_wr;
    sel_addr    = ext_gnt ? bus.ext_addr     : bus.core_addr;
    sel_wr_dat  = ext_gnt ? bus.ext_wr_dat   : bus.core_wr_dat;
    sel_byte_en = ext_gnt ? bus.ext_byte_en  : bus.core_byte_en;

    legal  = (sel_addr <= MEM_MSB) && (sel_addr[1:0] == 2'b00);
    access = any_gnt && legal;

    // SRAM pins are zero whenever no legal access is in flight.
    bus.mem_en      = access;
    bus.mem_wr      = access && sel_wr;
    bus.mem_addr    = access ? sel_addr[MEM_AW-1:0] : '0;
    bus.mem_wr_dat  = access ? sel_wr_dat  : '0;
    bus.mem_byte_en = access ? sel_byte_en : '0;

    bus.core_gnt = core_gnt;
    bus.ext_gnt  = ext_gnt;

    // Starvation counter: clear on any ext win, count core wins over a
    // waiting ext (saturating), otherwise hold.
    starve_d = starve_q;
    if (ext_gnt) begin
      starve_d = '0;
    end else if (both_req && core_gnt && (starve_q != 3'(MAX_STARVE))) begin
      starve_d = starve_q + 3'd1;
    end

    rsp_vld_d   = any_gnt;
    rsp_owner_d = ext_gnt ? OWN_EXT : OWN_CORE;
    rsp_err_d   = any_gnt && !legal;
    rsp_is_rd_d = any_gnt && !sel_wr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q    <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_owner_q <= OWN_CORE;
      rsp_err_q   <= 1'b0;
      rsp_is_rd_q <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_err_q   <= rsp_err_d;
      rsp_is_rd_q <= rsp_is_rd_d;
    end
  end

  // Response routing. Gating with rst_n drops a response whose grant happened
  // just before reset was asserted, before the pipeline register is cleared.
  always_comb begin
    rsp_live = rst_n && rsp_vld_q;
    rsp_dat  = (rsp_live && rsp_is_rd_q && !rsp_err_q) ? bus.mem_rd_dat : '0;

    bus.core_rd_vld = rsp_live && (rsp_owner_q == OWN_CORE);
    bus.core_err    = rsp_live && (rsp_owner_q == OWN_CORE) && rsp_err_q;
    bus.core_rd_dat = (rsp_owner_q == OWN_CORE) ? rsp_dat : '0;

    bus.ext_rd_vld  = rsp_live && (rsp_owner_q == OWN_EXT);
    bus.ext_err     = rsp_live && (rsp_owner_q == OWN_EXT) && rsp_err_q;
    bus.ext_rd_dat  = (rsp_owner_q == OWN_EXT) ? rsp_dat : '0;
  end

endmodule

// File: tb/tb_rvc_asap_dmem_arb.sv
// Bench for rvc_asap_dmem_arb: directed requests with a response scoreboard
// and a behavioural byte-enabled SRAM with one-cycle read latency.
// Inputs change 1 ns after posedge; all checks sample at negedge.
module tb_rvc_asap_dmem_arb;

  typedef struct packed {
    logic        owner;   // 0 = core, 1 = ext
    logic        err;
    logic [31:0] dat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];

  rvc_asap_dmem_arb_if #(.DATA_W(32), .MEM_AW(13)) bus ();

  rvc_asap_dmem_arb #(
    .DATA_W(32), .MEM_MSB(32'h1FFF), .MEM_AW(13), .MAX_STARVE(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: 2048 words, byte-enabled writes, registered read.
  logic [31:0] mem [0:2047];
  logic [31:0] rd_q;
  assign bus.mem_rd_dat = rd_q;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    rd_q = 32'h0;
  end

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_wr) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_byte_en[b]) mem[bus.mem_addr[12:2]][8*b +: 8] <= bus.mem_wr_dat[8*b +: 8];
      end else begin
        rd_q <= mem[bus.mem_addr[12:2]];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response is presented.
  always @(negedge clk) begin
    if (bus.core_rd_vld && bus.ext_rd_vld) begin
      check("single_owner", 32'd1, 32'd0);
    end else if (bus.core_rd_vld || bus.ext_rd_vld) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {31'd0, bus.ext_rd_vld}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_owner", {31'd0, bus.ext_rd_vld}, {31'd0, e.owner});
        if (e.owner) begin
          check("ext_rdata", bus.ext_rd_dat, e.dat);
          check("ext_err",   {31'd0, bus.ext_err}, {31'd0, e.err});
          check("core_idle", {bus.core_rd_dat[30:0], bus.core_err}, 32'd0);
        end else begin
          check("core_rdata", bus.core_rd_dat, e.dat);
          check("core_err",   {31'd0, bus.core_err}, {31'd0, e.err});
          check("ext_idle",   {bus.ext_rd_dat[30:0], bus.ext_err}, 32'd0);
        end
      end
    end
  end

  task automatic idle_all();
    bus.core_req = 0; bus.core_wr = 0; bus.core_addr = 0; bus.core_wr_dat = 0; bus.core_byte_en = 0;
    bus.ext_req  = 0; bus.ext_wr  = 0; bus.ext_addr  = 0; bus.ext_wr_dat  = 0; bus.ext_byte_en  = 0;
  endtask

  // Present one request, wait (bounded) for its grant, push the expected
  // response and check the SRAM enable in the grant cycle.
  task automatic issue(input bit is_ext, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdat, input logic [3:0] be,
                       input logic [31:0] exp_dat, input bit exp_err);
    bit got;
    got = 0;
    if (is_ext) begin
      bus.ext_req = 1; bus.ext_wr = wr; bus.ext_addr = addr; bus.ext_wr_dat = wdat; bus.ext_byte_en = be;
    end else begin
      bus.core_req = 1; bus.core_wr = wr; bus.core_addr = addr; bus.core_wr_dat = wdat; bus.core_byte_en = be;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (is_ext ? bus.ext_gnt : bus.core_gnt) got = 1;
    end
    if (!got) begin
      check("grant_timeout", 32'd0, 32'd1);
    end else begin
      check("mem_en", {31'd0, bus.mem_en}, {31'd0, !exp_err});
      exp_q.push_back('{owner: is_ext, err: exp_err, dat: exp_dat});
    end
    @(posedge clk); #1;
    if (is_ext) bus.ext_req = 0; else bus.core_req = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},  {30'd0, bus.core_gnt, bus.ext_gnt}, 32'd0);
    check({tag, "_vld"},  {28'd0, bus.core_rd_vld, bus.ext_rd_vld, bus.core_err, bus.ext_err}, 32'd0);
    check({tag, "_cdat"}, bus.core_rd_dat, 32'd0);
    check({tag, "_edat"}, bus.ext_rd_dat, 32'd0);
    check({tag, "_mem"},  {30'd0, bus.mem_en, bus.mem_wr}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] gseq;
    n_cmp = 0;
    n_bad = 0;
    idle_all();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    bus.core_req = 1;               // request held during reset must not be granted
    @(negedge clk);
    check_reset_outputs("reset");
    bus.core_req = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    check("idle_mem", {30'd0, bus.mem_en, bus.mem_wr}, 32'd0);
    check("idle_maddr", {19'd0, bus.mem_addr}, 32'd0);
    @(posedge clk); #1;

    // Preload via ext (stores acknowledge with zero data, no error).
    issue(1, 1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, 0);
    issue(1, 1, 32'h000, 32'h0000_1111, 4'hF, 32'h0, 0);
    issue(1, 1, 32'h004, 32'h0000_2222, 4'hF, 32'h0, 0);
    issue(1, 1, 32'h008, 32'h0000_3333, 4'hF, 32'h0, 0);
    issue(1, 1, 32'h200, 32'hAAAAAAAA, 4'hF, 32'h0, 0);

    // Single core load.
    issue(0, 0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 0);

    // Out-of-range store, misaligned load, then memory must be unchanged.
    issue(0, 1, 32'h2000, 32'h5555_5555, 4'hF, 32'h0, 1);
    issue(0, 0, 32'h102, 32'h0, 4'h0, 32'h0, 1);
    issue(0, 1, 32'h101, 32'h7777_7777, 4'hF, 32'h0, 1);
    issue(0, 0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 0);
    issue(0, 0, 32'h1FFC, 32'h0, 4'h0, 32'h0, 0);     // last legal word

    // Partial byte-enable store, then read back merged word.
    issue(1, 1, 32'h200, 32'h11223344, 4'b0011, 32'h0, 0);
    issue(0, 0, 32'h200, 32'h0, 4'h0, 32'hAAAA3344, 0);
    issue(1, 0, 32'h200, 32'h0, 4'h0, 32'hAAAA3344, 0);

    // Back-to-back core loads, one grant per cycle.
    issue(0, 0, 32'h0, 32'h0, 4'h0, 32'h0000_1111, 0);
    issue(0, 0, 32'h4, 32'h0, 4'h0, 32'h0000_2222, 0);
    issue(0, 0, 32'h8, 32'h0, 4'h0, 32'h0000_3333, 0);
    repeat (2) @(posedge clk);
    #1;

    // Contention: both requesters held high for ten cycles.
    bus.core_req = 1; bus.core_wr = 0; bus.core_addr = 32'h0;
    bus.ext_req  = 1; bus.ext_wr  = 0; bus.ext_addr  = 32'h4;
    gseq = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("one_gnt", {30'd0, bus.core_gnt, bus.ext_gnt},
            bus.ext_gnt ? 32'd1 : 32'd2);
      gseq[i] = bus.ext_gnt;
      if (bus.ext_gnt) exp_q.push_back('{owner: 1'b1, err: 1'b0, dat: 32'h0000_2222});
      else             exp_q.push_back('{owner: 1'b0, err: 1'b0, dat: 32'h0000_1111});
      @(posedge clk); #1;
    end
    check("starve_seq", {22'd0, gseq}, 32'b10_0001_0000);
    idle_all();
    repeat (3) @(posedge clk);
    #1;

    // Reset asserted the cycle after a core load grant drops the response.
    bus.core_req = 1; bus.core_wr = 0; bus.core_addr = 32'h100;
    @(negedge clk);
    check("pre_rst_gnt", {31'd0, bus.core_gnt}, 32'd1);
    @(posedge clk); #1;
    rst_n = 0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("midrst2");
    @(posedge clk); #1;
    rst_n = 1;
    bus.core_req = 0;
    issue(0, 0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 0);
    repeat (3) @(posedge clk);
    #1;

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
